// File: rtl/fir_decim_buffer.sv
// fir_decim_buffer: downstream stage of the 9-tap FIR filter.
// Discards WARMUP accepted samples after reset, decimates the filter's
// free-running output by DECIM and buffers the result in a DEPTH-entry
// show-ahead FIFO drained through a valid/ready handshake.
//
// Optional feature (macro FIR_DECIM_AVG_EN):
//   defined   - each decimated sample is the floor-mean of its DECIM-sample group
//   undefined - each decimated sample is the last sample of its group (pick-last)
//
// Ports:
//   clk       sole clock, rising edge
//   rstN      asynchronous active-low reset
//   inValid   inData carries a sample this cycle
//   inData    signed filter output sample
//   outValid  FIFO head holds a sample
//   outReady  consumer accepts the head this cycle
//   outData   signed FIFO head sample (holds last value when empty)
//   level     FIFO occupancy
//   overflow  sticky flag: a decimated sample was dropped on a full FIFO
//   clrOvf    synchronous clear of overflow (a same-edge drop wins)
module fir_decim_buffer #(
  parameter int unsigned DECIM  = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned WARMUP = 12
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     inValid,
  input  logic signed [15:0]       inData,
  output logic                     outValid,
  input  logic                     outReady,
  output logic signed [15:0]       outData,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clrOvf
);

  localparam int unsigned AddrW  = $clog2(DEPTH);
  localparam int unsigned LvlW   = AddrW + 1;
  localparam int unsigned ShiftW = $clog2(DECIM);
  localparam int unsigned PhaseW = (DECIM > 1) ? ShiftW : 1;
  localparam int unsigned WarmW  = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  logic [WarmW-1:0]  warm_q;
  logic [PhaseW-1:0] phase_q;
  logic              accept_run;
  logic              group_end;
  logic signed [15:0] dec_data;

  assign accept_run = inValid && (warm_q == '0);
  assign group_end  = accept_run && (phase_q == PhaseW'(DECIM - 1));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      warm_q  <= WarmW'(WARMUP);
      phase_q <= '0;
    end else if (inValid) begin
      if (warm_q != '0) begin
        warm_q <= warm_q - 1'b1;
      end else begin
        phase_q <= group_end ? '0 : phase_q + 1'b1;
      end
    end
  end

`ifdef FIR_DECIM_AVG_EN
  localparam int unsigned AccW = 16 + ShiftW;

  logic signed [AccW-1:0] acc_q;
  logic signed [AccW-1:0] acc_base;
  logic signed [AccW-1:0] acc_sum;
  logic signed [AccW-1:0] acc_avg;

  // Phase 0 starts a fresh group, so the stale sum is ignored there.
  assign acc_base = (phase_q == '0) ? '0 : acc_q;
  assign acc_sum  = acc_base + AccW'(inData);
  // Arithmetic shift floors toward minus infinity; the mean always fits 16 bits.
  assign acc_avg  = acc_sum >>> ShiftW;
  assign dec_data = acc_avg[15:0];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      acc_q <= '0;
    end else if (accept_run) begin
      acc_q <= acc_sum;
    end
  end
`else
  assign dec_data = inData;
`endif

  // FIFO
  logic signed [15:0] mem_q [DEPTH];
  logic [AddrW-1:0]   wptr_q, rptr_q, rptr_d;
  logic [LvlW-1:0]    level_q, level_d;
  logic signed [15:0] data_q, data_d;
  logic               ovf_q;
  logic               push, pop;

  assign pop  = (level_q != '0) && outReady;
  // A full FIFO still takes the sample if the head leaves on the same edge.
  assign push = group_end && ((level_q != LvlW'(DEPTH)) || pop);

  always_comb begin
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
    // Registered head: the slot being written this edge is not yet in mem_q.
    data_d = data_q;
    if (level_d != '0) begin
      if (push && (rptr_d == wptr_q)) begin
        data_d = dec_data;
      end else begin
        data_d = mem_q[rptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= dec_data;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      rptr_q  <= rptr_d;
      level_q <= level_d;
      data_q  <= data_d;
      if (group_end && !push) begin
        ovf_q <= 1'b1;
      end else if (clrOvf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign outValid = (level_q != '0);
  assign outData  = data_q;
  assign level    = level_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Scoreboard bench for fir_decim_buffer. Two instances: u_a with the default
// parameters (DECIM 4, WARMUP 12, DEPTH 8) and u_b with DECIM 1, WARMUP 0.
// Expected samples are queued when stimulus is issued; per-instance monitors
// pop and compare whenever the DUT hands over a sample.
module tb_fir_decim_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n, a_in_valid, a_out_valid, a_out_ready, a_ovf, a_clr;
  logic [15:0] a_in_data, a_out_data;
  logic [3:0]  a_level;
  logic        b_rst_n, b_in_valid, b_out_valid, b_out_ready, b_ovf, b_clr;
  logic [15:0] b_in_data, b_out_data;
  logic [3:0]  b_level;

  fir_decim_buffer u_a (
    .clk      (clk),
    .rstN     (a_rst_n),
    .inValid  (a_in_valid),
    .inData   (a_in_data),
    .outValid (a_out_valid),
    .outReady (a_out_ready),
    .outData  (a_out_data),
    .level    (a_level),
    .overflow (a_ovf),
    .clrOvf   (a_clr)
  );

  fir_decim_buffer #(
    .DECIM  (1),
    .DEPTH  (8),
    .WARMUP (0)
  ) u_b (
    .clk      (clk),
    .rstN     (b_rst_n),
    .inValid  (b_in_valid),
    .inData   (b_in_data),
    .outValid (b_out_valid),
    .outReady (b_out_ready),
    .outData  (b_out_data),
    .level    (b_level),
    .overflow (b_ovf),
    .clrOvf   (b_clr)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] q_a [$];
  logic [15:0] q_b [$];

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Monitors: a handshake seen at the falling edge completes on the next rise.
  always @(negedge clk) begin
    if (a_out_valid && a_out_ready) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected act=%0h req=none", a_out_data);
      end else begin
        chk("a_out_data", {16'h0, a_out_data}, {16'h0, q_a.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (b_out_valid && b_out_ready) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected act=%0h req=none", b_out_data);
      end else begin
        chk("b_out_data", {16'h0, b_out_data}, {16'h0, q_b.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic accept_a(input logic [15:0] d);
    a_in_valid = 1'b1;
    a_in_data  = d;
    step();
    a_in_valid = 1'b0;
    a_in_data  = 16'h5A5A;
  endtask

  task automatic accept_b(input logic [15:0] d);
    b_in_valid = 1'b1;
    b_in_data  = d;
    step();
    b_in_valid = 1'b0;
    b_in_data  = 16'hA5A5;
  endtask

  task automatic reset_a();
    a_rst_n = 1'b0;
    #1;
    q_a.delete();
    step();
    a_rst_n = 1'b1;
  endtask

  // Data = accept index 1..n; group ends at index 12+4m.
  task automatic feed_a(input int n, input bit gaps, input bit chk_first);
    for (int k = 1; k <= n; k++) begin
      if (k > 12 && ((k - 12) % 4) == 0) begin
`ifdef FIR_DECIM_AVG_EN
        q_a.push_back(16'(k - 2));
`else
        q_a.push_back(16'(k));
`endif
      end
      accept_a(16'(k));
      if (chk_first && k == 15) chk("a_first_early", {31'h0, a_out_valid}, 32'd0);
      if (chk_first && k == 16) chk("a_first_valid", {31'h0, a_out_valid}, 32'd1);
      if (gaps) step();
    end
  endtask

  initial begin
    a_rst_n = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1; a_clr = 1'b0;
    b_rst_n = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_clr = 1'b0;
    idle(2);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;

    chk("a_rst_valid", {31'h0, a_out_valid}, 32'd0);
    chk("a_rst_level", {28'h0, a_level}, 32'd0);
    chk("a_rst_ovf", {31'h0, a_ovf}, 32'd0);
    chk("a_rst_data", {16'h0, a_out_data}, 32'd0);

    // Back-pressure and overflow: 100..107 kept, 108/109 dropped.
    for (int i = 0; i < 10; i++) begin
      if (i < 8) q_b.push_back(16'(100 + i));
      accept_b(16'(100 + i));
    end
    chk("b_full_level", {28'h0, b_level}, 32'd8);
    chk("b_full_ovf", {31'h0, b_ovf}, 32'd1);
    b_out_ready = 1'b1;
    idle(9);
    chk("b_drain_level", {28'h0, b_level}, 32'd0);
    chk("b_ovf_sticky", {31'h0, b_ovf}, 32'd1);
    b_clr = 1'b1;
    step();
    b_clr = 1'b0;
    chk("b_ovf_clr", {31'h0, b_ovf}, 32'd0);

    // Full FIFO with a pop on the same edge as the push.
    b_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      q_b.push_back(16'(120 + i));
      accept_b(16'(120 + i));
    end
    b_out_ready = 1'b1;
    q_b.push_back(16'd200);
    accept_b(16'd200);
    b_out_ready = 1'b0;
    chk("b_pushpop_level", {28'h0, b_level}, 32'd8);
    chk("b_pushpop_ovf", {31'h0, b_ovf}, 32'd0);
    // Drop and clear on the same edge: set wins.
    b_clr = 1'b1;
    accept_b(16'd300);
    chk("b_setwins_ovf", {31'h0, b_ovf}, 32'd1);
    chk("b_setwins_level", {28'h0, b_level}, 32'd8);
    step();
    b_clr = 1'b0;
    chk("b_clr2_ovf", {31'h0, b_ovf}, 32'd0);
    b_out_ready = 1'b1;
    idle(10);
    chk("b_drain2_level", {28'h0, b_level}, 32'd0);

    // DECIM 1, consumer always ready: one sample per cycle, no drops.
    for (int i = 0; i < 10; i++) begin
      q_b.push_back(16'(400 + i));
      accept_b(16'(400 + i));
    end
    idle(3);
    chk("b_stream_ovf", {31'h0, b_ovf}, 32'd0);
    chk("b_stream_level", {28'h0, b_level}, 32'd0);

    // Warm-up and decimation, gap-free then with inValid toggling.
    feed_a(32, 1'b0, 1'b1);
    idle(4);
    reset_a();
    feed_a(32, 1'b1, 1'b0);
    idle(4);

    // Negative and full-scale groups.
    reset_a();
    for (int i = 0; i < 12; i++) accept_a(16'h0);
`ifdef FIR_DECIM_AVG_EN
    q_a.push_back(16'hFFFD);
`else
    q_a.push_back(16'hFFFE);
`endif
    accept_a(16'hFFFD);
    accept_a(16'hFFFD);
    accept_a(16'hFFFD);
    accept_a(16'hFFFE);
    q_a.push_back(16'h7FFF);
    repeat (4) accept_a(16'h7FFF);
    idle(4);
    chk("a_neg_level", {28'h0, a_level}, 32'd0);

    // Reset mid-stream with five samples buffered.
    reset_a();
    a_out_ready = 1'b0;
    feed_a(32, 1'b0, 1'b0);
    chk("a_mid_level", {28'h0, a_level}, 32'd5);
    a_rst_n = 1'b0;
    #1;
    chk("a_async_valid", {31'h0, a_out_valid}, 32'd0);
    chk("a_async_level", {28'h0, a_level}, 32'd0);
    chk("a_async_ovf", {31'h0, a_ovf}, 32'd0);
    q_a.delete();
    step();
    a_rst_n = 1'b1;
    a_out_ready = 1'b1;
    feed_a(16, 1'b0, 1'b1);
    idle(4);

    chk("a_queue_empty", 32'(q_a.size()), 32'd0);
    chk("b_queue_empty", 32'(q_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_decim_buffer.md
# fir_decim_buffer

Downstream stage of the 9-tap FIR filter: samples the filter's free-running 16-bit signed output, discards pipeline warm-up samples after reset, decimates by DECIM, and buffers the decimated stream in a small FIFO that is drained through a valid/ready handshake. It is the boundary between the filter's every-cycle sample stream and back-pressured consumers such as a UART or DMA packer.

## Interface
- DECIM, 4, decimation factor; power of two, 1..64
- DEPTH, 8, FIFO depth in samples; power of two, 2..64
- WARMUP, 12, accepted input samples discarded after reset (covers the filter's 9-tap fill and 4-cycle pipeline)
- clk  input  1  sole clock, rising edge
- rstN  input  1  asynchronous, active-low reset
- inValid  input  1  inData is a sample this cycle (tied high when the filter free-runs)
- inData  input  16  signed filter output
- outValid  output  1  FIFO head holds a sample
- outReady  input  1  consumer accepts the head this cycle
- outData  output  16  signed FIFO head sample
- level  output  $clog2(DEPTH)+1  FIFO occupancy
- overflow  output  1  sticky: a decimated sample was dropped because the FIFO was full
- clrOvf  input  1  synchronous clear of overflow

## Operation
- Reset (rstN low, asynchronous): warm-up counter = WARMUP, phase counter = 0, accumulator = 0, FIFO empty, outValid = 0, outData = 0, level = 0, overflow = 0.
- Accept: inValid high at a clk edge. inValid low freezes all counters and the accumulator.
- Warm-up: while the warm-up counter is nonzero, each accept decrements it and discards the sample; the phase counter does not advance.
- Decimation: after warm-up, each accept advances phase 0..DECIM-1, then wraps. The accept that occurs at phase DECIM-1 produces one decimated sample (see Configuration).
- Push: a decimated sample is written when level < DEPTH, or when level == DEPTH and a pop happens on the same edge. Otherwise the sample is dropped, overflow is set, and the phase still wraps.
- Pop: outValid && outReady. Advances the read pointer. outReady while outValid = 0 is ignored.
- Simultaneous push and pop: level is unchanged and the pointers wrap modulo DEPTH.
- overflow: set by a drop, cleared by clrOvf. If both occur on the same edge, set wins.
- outData is the memory entry at the read pointer, with show-ahead behaviour. It holds its last value when the FIFO is empty. It must remain stable while outValid && !outReady.

## Timing
- Push to outValid: a sample written at edge N is visible on outData/outValid after edge N. There is no same-cycle bypass when the FIFO is empty.
- First output with free-running input (inValid = 1 from reset release): the first decimated sample is pushed on accept WARMUP+DECIM, counted from 1. With the defaults, outValid rises after the 16th edge.
- Sustained throughput: one sample per DECIM accepted inputs. With DECIM = 1 and outReady held high, throughput is one sample per cycle and there are no drops.
- level updates on the same edge as the push/pop that changes it.
- Reset asserted mid-stream: the FIFO contents are lost, outValid drops asynchronously, and warm-up restarts.

## Configuration
- FIR_DECIM_AVG_EN defined:
  - The decimated sample is the mean of the DECIM accepted samples in the group.
  - Use an 16+log2(DECIM)-bit signed accumulator: sum the group, then arithmetic-shift right by log2(DECIM), truncating toward minus infinity.
  - The accumulator restarts at the first sample of each group.
- FIR_DECIM_AVG_EN undefined:
  - The decimated sample is the accepted sample at phase DECIM-1 (pick-last).
  - No accumulator is instantiated.

## Test plan
- Warm-up: defaults, inValid = 1, inData = accept index 1,2,3…, outReady = 1 -> first outData = 16 (pick-last) or 14 (avg of 13..16 = 58>>2), then every 4 samples.
- Back-pressure/overflow: DECIM = 1, WARMUP = 0, outReady = 0 for 10 accepts of 100..109 -> level saturates at 8, overflow = 1, then draining yields 100..107 in order; clrOvf clears the flag.
- Full with simultaneous pop: FIFO full, outReady = 1 while pushing 200 -> accepted, level stays 8, overflow stays 0.
- Negative averaging (AVG_EN, DECIM = 4): group −3,−3,−3,−2 -> outData = −3 (−11>>2); group 0x7FFF×4 -> 0x7FFF with no wrap.
- inValid gaps: inValid toggled 1,0,1,0 -> counters advance only on high cycles, and the output sequence is identical to the gap-free run.
- Reset mid-stream: rstN pulsed low while level = 5 -> outValid = 0, level = 0, overflow = 0 immediately; after release the first output appears again after WARMUP+DECIM accepts.
